mem_responder: RTL and testbench

- Memory-side responder for the cache's memory request interface: flag, address, write data, byte mask, busy and done.
- Serves single-word reads and byte-masked writes from an internal word RAM after a fixed, parameterised latency.
- Sits between the cache miss/write-through port and the top level, and stands in as main memory for simulation and FPGA builds.
- Supports back-to-back requests issued in the same cycle as done, as the cache's critical-word refill sequence requires.

---
 rtl/mem_pkg.sv | 22 ++
 rtl/mem_word_ram.sv | 30 +++
 rtl/mem_responder.sv | 183 ++++++++++++++++++
 tb/tb_mem_responder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: request flag codes, the MMIO
// register address and the FSM state encoding.
package mem_pkg;

   localparam logic [1:0]  RW_IDLE  = 2'b00;
   localparam logic [1:0]  RW_READ  = 2'b01;
   localparam logic [1:0]  RW_WRITE = 2'b10;

   // Byte address of the non-cached I/O register (RAM word 64 otherwise).
   localparam logic [31:0] MMIO_ADDR = 32'h100;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   // 2'b11 is served as a read, so bit 0 alone decides the direction.
   function automatic logic is_read(input logic [1:0] flag);
      return flag[0];
   endfunction

endpackage

// File: rtl/mem_word_ram.sv
// 32-bit word RAM with per-byte write enables, one write port and one
// registered read port. The read register only updates when re is high, so
// the last read word stays on rdata until the next read.
module mem_word_ram
   import mem_pkg::*;
#(
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic [3:0]            we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [31:0]           wdata,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [31:0]           rdata
);

   logic [31:0] mem [2**ADDR_WIDTH];

   // Byte-lane writes and read-enabled registered read.
   // NOTE: the array has no reset; resetting a RAM turns it into a huge
   // register file and prevents block-RAM inference.
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (we[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one read or byte-masked write at a time and
// completes it after LATENCY cycles with a one-cycle done pulse. A new request
// may be presented in the done cycle.
// Optional MMIO register at byte address 0x100: define MEM_RESPONDER_MMIO_EN.
module mem_responder
   import mem_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int LATENCY    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  rw_flag_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] w_data_i,
   input  logic [3:0]  w_mask_i,
   output logic [31:0] r_data_o,
   output logic        busy,
   output logic        done,
   output logic        err_o
`ifdef MEM_RESPONDER_MMIO_EN
   ,
   output logic        io_tx_valid,
   output logic [7:0]  io_tx_data,
   input  logic [7:0]  io_rx_data
`endif
);

   state_t                state_q, state_d;
   logic [7:0]            cnt_q, cnt_d;
   logic                  accept, commit;

   // Request decode on the live inputs.
   logic                  req_oor, req_mmio;
   assign req_oor = (addr_i >> (ADDR_WIDTH + 2)) != 32'd0;
`ifdef MEM_RESPONDER_MMIO_EN
   assign req_mmio = (addr_i[31:2] == MMIO_ADDR[31:2]);
`else
   assign req_mmio = 1'b0;
`endif

   // Request captured at accept; later input changes are ignored.
   logic                  lat_read, lat_oor, lat_mmio;
   logic [ADDR_WIDTH-1:0] lat_word;
   logic [31:0]           lat_data;
   logic [3:0]            lat_mask;

   // Operands of the request being committed this edge.
   logic                  c_read, c_oor, c_mmio;
   logic [ADDR_WIDTH-1:0] c_word;
   logic [31:0]           c_data;
   logic [3:0]            c_mask;

   // Read-data source: RAM read register or a local holding register.
   logic                  rd_from_ram;
   logic [31:0]           rd_aux, ram_rdata;
   logic [3:0]            ram_we;
   logic                  ram_re;

   // Next-state, counter and commit decision.
   // NOTE: every output of this block gets a default first so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      commit  = 1'b0;
      c_read  = lat_read;
      c_oor   = lat_oor;
      c_mmio  = lat_mmio;
      c_word  = lat_word;
      c_data  = lat_data;
      c_mask  = lat_mask;
      case (state_q)
         S_IDLE: begin
            if (rw_flag_i != RW_IDLE) begin
               accept = 1'b1;
               if (LATENCY == 1) begin
                  // Single-cycle latency commits straight from the inputs.
                  commit = 1'b1;
                  c_read = is_read(rw_flag_i);
                  c_oor  = req_oor;
                  c_mmio = req_mmio;
                  c_word = addr_i[ADDR_WIDTH+1:2];
                  c_data = w_data_i;
                  c_mask = w_mask_i;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = 8'(LATENCY - 1);
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
               state_d = S_IDLE;
               commit  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register with registered busy and done outputs.
   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 8'd0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy    <= (state_d == S_WAIT);
         done    <= commit;
      end
   end

   // Capture the accepted request; data-path only, so no reset is needed.
   always_ff @(posedge clk) begin
      if (accept) begin
         lat_read <= is_read(rw_flag_i);
         lat_oor  <= req_oor;
         lat_mmio <= req_mmio;
         lat_word <= addr_i[ADDR_WIDTH+1:2];
         lat_data <= w_data_i;
         lat_mask <= w_mask_i;
      end
   end

   // RAM only sees in-range, non-MMIO commits.
   assign ram_we = (commit && !c_read && !c_oor && !c_mmio) ? c_mask : 4'b0000;
   assign ram_re = commit && c_read && !c_oor && !c_mmio;

   mem_word_ram #(
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (c_word),
      .wdata (c_data),
      .re    (ram_re),
      .raddr (c_word),
      .rdata (ram_rdata)
   );

   // Read-source select, sticky drop flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_from_ram <= 1'b0;
         rd_aux      <= 32'd0;
         err_o       <= 1'b0;
      end else begin
         if (rw_flag_i != RW_IDLE && busy) err_o <= 1'b1;
         if (commit && c_read) begin
            rd_from_ram <= !c_oor && !c_mmio;
`ifdef MEM_RESPONDER_MMIO_EN
            rd_aux      <= c_mmio ? {24'd0, io_rx_data} : 32'd0;
`else
            rd_aux      <= 32'd0;
`endif
         end
      end
   end

   assign r_data_o = rd_from_ram ? ram_rdata : rd_aux;

`ifdef MEM_RESPONDER_MMIO_EN
   // Transmit pulse for writes to the I/O register with byte 0 enabled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         io_tx_valid <= 1'b0;
         io_tx_data  <= 8'd0;
      end else begin
         io_tx_valid <= commit && !c_read && c_mmio && c_mask[0];
         if (commit && !c_read && c_mmio && c_mask[0]) io_tx_data <= c_data[7:0];
      end
   end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder (ADDR_WIDTH=16, LATENCY=4).
// A transaction-level model predicts busy/done/r_data_o/err_o every cycle;
// directed literal checks pin the model on the key scenarios.
module tb_mem_responder;

   localparam int AW = 16;
   localparam int L  = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  rw_flag_i = 2'b00;
   logic [31:0] addr_i = 32'd0;
   logic [31:0] w_data_i = 32'd0;
   logic [3:0]  w_mask_i = 4'd0;
   logic [31:0] r_data_o;
   logic        busy, done, err_o;
`ifdef MEM_RESPONDER_MMIO_EN
   logic        io_tx_valid;
   logic [7:0]  io_tx_data;
   logic [7:0]  io_rx_data = 8'h5A;
`endif

   mem_responder #(
      .ADDR_WIDTH(AW),
      .LATENCY(L)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rw_flag_i (rw_flag_i),
      .addr_i    (addr_i),
      .w_data_i  (w_data_i),
      .w_mask_i  (w_mask_i),
      .r_data_o  (r_data_o),
      .busy      (busy),
      .done      (done),
      .err_o     (err_o)
`ifdef MEM_RESPONDER_MMIO_EN
      ,
      .io_tx_valid (io_tx_valid),
      .io_tx_data  (io_tx_data),
      .io_rx_data  (io_rx_data)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit          m_job = 1'b0;
   int          m_t;
   logic [1:0]  m_f;
   logic [31:0] m_a, m_d;
   logic [3:0]  m_m;
   logic [31:0] m_rdata = 32'd0;
   bit          m_err = 1'b0;
   logic [31:0] m_mem [int];
   bit          m_txv = 1'b0;
   logic [7:0]  m_txd = 8'd0;

   function automatic bit out_of_range(input logic [31:0] a);
      return a >= 32'(4 * (2 ** AW));
   endfunction

   function automatic bit is_io(input logic [31:0] a);
`ifdef MEM_RESPONDER_MMIO_EN
      return (a / 4) == 32'd64;
`else
      return (a != a);
`endif
   endfunction

   always @(negedge clk) begin
      bit e_busy, e_done;
      int w;
      if (rst) begin
         m_job = 1'b0; m_rdata = 32'd0; m_err = 1'b0; m_txv = 1'b0; m_txd = 8'd0;
         e_busy = 1'b0; e_done = 1'b0;
      end else begin
         e_busy = m_job && (cyc > m_t) && (cyc < m_t + L);
         e_done = m_job && (cyc == m_t + L);
         m_txv  = 1'b0;
         if (e_done) begin
            w = int'(m_a / 4);
            if (m_f[0]) begin
               if (out_of_range(m_a)) m_rdata = 32'd0;
`ifdef MEM_RESPONDER_MMIO_EN
               else if (is_io(m_a)) m_rdata = {24'd0, io_rx_data};
`endif
               else m_rdata = m_mem.exists(w) ? m_mem[w] : 32'd0;
            end else if (is_io(m_a)) begin
               if (m_m[0]) begin m_txv = 1'b1; m_txd = m_d[7:0]; end
            end else if (!out_of_range(m_a)) begin
               if (!m_mem.exists(w)) m_mem[w] = 32'd0;
               for (int b = 0; b < 4; b++)
                  if (m_m[b]) m_mem[w][8*b +: 8] = m_d[8*b +: 8];
            end
            m_job = 1'b0;
         end
      end
      check("busy", {31'd0, busy}, {31'd0, e_busy});
      check("done", {31'd0, done}, {31'd0, e_done});
      check("r_data_o", r_data_o, m_rdata);
      check("err_o", {31'd0, err_o}, {31'd0, m_err});
`ifdef MEM_RESPONDER_MMIO_EN
      check("io_tx_valid", {31'd0, io_tx_valid}, {31'd0, m_txv});
      check("io_tx_data", {24'd0, io_tx_data}, {24'd0, m_txd});
`endif
      if (!rst && rw_flag_i != 2'b00) begin
         if (e_busy) m_err = 1'b1;
         else begin
            m_job = 1'b1; m_t = cyc; m_f = rw_flag_i;
            m_a = addr_i; m_d = w_data_i; m_m = w_mask_i;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic goto(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic issue(input int t, input logic [1:0] f, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m);
      goto(t);
      rw_flag_i = f; addr_i = a; w_data_i = d; w_mask_i = m;
   endtask

   // Idle with junk on the other inputs: only latched values may matter.
   task automatic idle(input int t);
      goto(t);
      rw_flag_i = 2'b00; addr_i = 32'hFFFF_FFFC; w_data_i = 32'h5555_5555; w_mask_i = 4'hF;
   endtask

   task automatic at_neg(input int n);
      goto(n);
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      at_neg(1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_rdata", r_data_o, 32'd0);
      check("rst_err", {31'd0, err_o}, 32'd0);
      goto(3);
      rst = 1'b0;

      // Full write then back-to-back read in the done cycle.
      issue(10, 2'b10, 32'h40, 32'hDEADBEEF, 4'hF);
      idle(11);
      at_neg(12);
      check("busy_in_wait", {31'd0, busy}, 32'd1);
      issue(14, 2'b01, 32'h40, 32'd0, 4'h0);
      @(negedge clk);
      check("first_done", {31'd0, done}, 32'd1);
      check("busy_done_cycle", {31'd0, busy}, 32'd0);
      idle(15);
      at_neg(17);
      check("busy_second", {31'd0, busy}, 32'd1);
      at_neg(18);
      check("second_done", {31'd0, done}, 32'd1);
      check("read_back", r_data_o, 32'hDEADBEEF);

      // Byte-masked write.
      issue(20, 2'b10, 32'h40, 32'h000000AA, 4'b0001);
      idle(21);
      issue(24, 2'b01, 32'h40, 32'd0, 4'h0);
      idle(25);
      at_neg(28);
      check("masked_write", r_data_o, 32'hDEADBEAA);

      // Request while busy is dropped and flagged.
      issue(30, 2'b01, 32'h40, 32'd0, 4'h0);
      idle(31);
      issue(32, 2'b01, 32'h44, 32'd0, 4'h0);
      idle(33);
      @(negedge clk);
      check("err_set", {31'd0, err_o}, 32'd1);
      at_neg(36);
      check("no_second_done", {31'd0, done}, 32'd0);

      // Out-of-range read returns 0; out-of-range write does not alias word 0.
      issue(38, 2'b10, 32'h0, 32'hCAFEF00D, 4'hF);
      idle(39);
      issue(42, 2'b01, 32'h0004_0000, 32'd0, 4'h0);
      idle(43);
      at_neg(46);
      check("oor_done", {31'd0, done}, 32'd1);
      check("oor_read", r_data_o, 32'd0);
      goto(46);
      issue(46, 2'b10, 32'h0004_0000, 32'h11111111, 4'hF);
      idle(47);
      issue(50, 2'b01, 32'h0, 32'd0, 4'h0);
      idle(51);
      at_neg(54);
      check("oor_write_dropped", r_data_o, 32'hCAFEF00D);

      // Reset in the middle of a write.
      issue(56, 2'b10, 32'h80, 32'h0BADC0DE, 4'hF);
      idle(57);
      issue(60, 2'b10, 32'h80, 32'h12345678, 4'hF);
      idle(61);
      goto(62);
      #1 rst = 1'b1;
      #1;
      check("rst_mid_busy", {31'd0, busy}, 32'd0);
      check("rst_mid_done", {31'd0, done}, 32'd0);
      goto(63);
      rst = 1'b0;
      at_neg(64);
      check("rst_no_done", {31'd0, done}, 32'd0);
      at_neg(65);
      check("rst_clears_err", {31'd0, err_o}, 32'd0);
      issue(66, 2'b01, 32'h80, 32'd0, 4'h0);
      idle(67);
      at_neg(70);
      check("write_aborted", r_data_o, 32'h0BADC0DE);

      // Zero mask, sparse mask, and flag 2'b11 as read.
      issue(72, 2'b10, 32'h40, 32'h0, 4'h0);
      idle(73);
      issue(76, 2'b10, 32'h80, 32'hAABBCCDD, 4'b1010);
      idle(77);
      issue(80, 2'b11, 32'h80, 32'd0, 4'h0);
      idle(81);
      at_neg(84);
      check("sparse_mask", r_data_o, 32'hAAADCCDE);
      goto(84);
      issue(84, 2'b01, 32'h40, 32'd0, 4'h0);
      idle(85);
      at_neg(88);
      check("zero_mask", r_data_o, 32'hDEADBEAA);

      // Address 0x100: I/O register with the feature, plain RAM without.
      issue(90, 2'b10, 32'h100, 32'h00000041, 4'hF);
      idle(91);
`ifdef MEM_RESPONDER_MMIO_EN
      at_neg(94);
      check("tx_valid", {31'd0, io_tx_valid}, 32'd1);
      check("tx_data", {24'd0, io_tx_data}, 32'h41);
`endif
      issue(96, 2'b01, 32'h100, 32'd0, 4'h0);
      idle(97);
      at_neg(100);
`ifdef MEM_RESPONDER_MMIO_EN
      check("io_read", r_data_o, 32'h0000005A);
`else
      check("word64_read", r_data_o, 32'h00000041);
`endif

      goto(105);
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
